// File: rtl/alu_reservation_station.sv
// -----------------------------------------------------------------------------
// alu_reservation_station
//
// Bank of NUM_ENTRIES reservation-station entries for the ALU class. Tasks
// arrive from the issue queue into the entry it names. Missing operands are
// captured from the common data bus (CDB) by producer tag. The oldest READY
// entry issues through a registered valid/ready output stage.
//
// Parameters
//   NUM_ENTRIES  entries in the bank (2..8)
//   TAGW         producer tag width, tag 0 means "no dependency"
//   OPW          ALU operation code width
//   XLEN         operand / data width
//
// Ports
//   CLK, RST_N         clock (rising edge) and synchronous active-low reset
//   FLUSH              squash all entries and the output stage
//   DISP_*             dispatch strobe, target entry, op, src tags/values, dest tag
//   CDB_*              result broadcast: valid, tag, data
//   BUSY               per-entry occupied flags
//   DISP_ERR           one-cycle pulse: dispatch to an occupied entry was dropped
//   FU_VALID/FU_READY  issue handshake to the ALU
//   FU_OP/A/B/DTAG     issued operation, operands and destination tag
//   STAT_ISSUED/STALL  saturating handshake / stall counters
//
// Build option
//   RS_STATS_EN  when defined the statistics counters are built. When it is
//                undefined, STAT_ISSUED and STAT_STALL are tied to zero.
// -----------------------------------------------------------------------------
module alu_reservation_station #(
  parameter int NUM_ENTRIES = 2,
  parameter int TAGW        = 4,
  parameter int OPW         = 4,
  parameter int XLEN        = 32,
  localparam int IDXW       = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   FLUSH,
  input  logic                   DISP_VALID,
  input  logic [IDXW-1:0]        DISP_IDX,
  input  logic [OPW-1:0]         DISP_OP,
  input  logic [TAGW-1:0]        DISP_QJ,
  input  logic [TAGW-1:0]        DISP_QK,
  input  logic [XLEN-1:0]        DISP_VJ,
  input  logic [XLEN-1:0]        DISP_VK,
  input  logic [TAGW-1:0]        DISP_DTAG,
  input  logic                   CDB_VALID,
  input  logic [TAGW-1:0]        CDB_TAG,
  input  logic [XLEN-1:0]        CDB_DATA,
  output logic [NUM_ENTRIES-1:0] BUSY,
  output logic                   DISP_ERR,
  output logic                   FU_VALID,
  input  logic                   FU_READY,
  output logic [OPW-1:0]         FU_OP,
  output logic [XLEN-1:0]        FU_A,
  output logic [XLEN-1:0]        FU_B,
  output logic [TAGW-1:0]        FU_DTAG,
  output logic [15:0]            STAT_ISSUED,
  output logic [15:0]            STAT_STALL
);

  typedef enum logic [1:0] {
    ST_FREE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_READY = 2'd2
  } ent_state_t;

  typedef struct packed {
    logic [OPW-1:0]  op;
    logic [TAGW-1:0] qj;
    logic [TAGW-1:0] qk;
    logic [XLEN-1:0] vj;
    logic [XLEN-1:0] vk;
    logic [TAGW-1:0] dtag;
  } ent_t;

  ent_state_t state_q [NUM_ENTRIES];
  ent_state_t state_d [NUM_ENTRIES];
  ent_t       ent_q   [NUM_ENTRIES];
  ent_t       ent_d   [NUM_ENTRIES];
  // older_q[j][i] = 1 : entry j was dispatched before entry i
  logic [NUM_ENTRIES-1:0] older_q [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] older_d [NUM_ENTRIES];

  logic [NUM_ENTRIES-1:0] ready_vec, free_vec, tgt_vec, sel_vec;
  ent_t                   sel_ent;
  logic                   any_ready, load, disp_ok, disp_err_d;
  logic                   byp_j, byp_k;

  logic                   fu_valid_q;
  logic [OPW-1:0]         fu_op_q;
  logic [XLEN-1:0]        fu_a_q, fu_b_q;
  logic [TAGW-1:0]        fu_dtag_q;
  logic                   disp_err_q;

  // ---------------------------------------------------------------------------
  // Selection: oldest READY entry, plus dispatch target decode.
  // ---------------------------------------------------------------------------
  // NOTE: every variable written in a combinational block gets a default at
  // the top, so no path can leave it unassigned and infer a latch.
  always_comb begin
    ready_vec = '0;
    free_vec  = '0;
    tgt_vec   = '0;
    sel_vec   = '0;
    sel_ent   = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      ready_vec[i] = (state_q[i] == ST_READY);
      free_vec[i]  = (state_q[i] == ST_FREE);
      tgt_vec[i]   = (DISP_IDX == IDXW'(i));
    end
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      sel_vec[i] = ready_vec[i];
      for (int j = 0; j < NUM_ENTRIES; j++) begin
        if (j != i && ready_vec[j] && older_q[j][i]) sel_vec[i] = 1'b0;
      end
      if (sel_vec[i]) sel_ent = ent_q[i];
    end
    any_ready  = |ready_vec;
    load       = any_ready && (!fu_valid_q || FU_READY);
    // An entry that frees this cycle is still READY here, so dispatching to it errors.
    disp_ok    = DISP_VALID && |(tgt_vec & free_vec);
    disp_err_d = DISP_VALID && !disp_ok;
    byp_j      = CDB_VALID && (CDB_TAG != '0) && (DISP_QJ == CDB_TAG);
    byp_k      = CDB_VALID && (CDB_TAG != '0) && (DISP_QK == CDB_TAG);
  end

  always_comb begin
    BUSY = ~free_vec;
  end

  // ---------------------------------------------------------------------------
  // Entry next-state: dispatch, wakeup, issue, age update. FLUSH overrides.
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      state_d[i] = state_q[i];
      ent_d[i]   = ent_q[i];
      older_d[i] = older_q[i];
    end
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      unique case (state_q[i])
        ST_FREE: begin
          if (disp_ok && tgt_vec[i]) begin
            ent_d[i].op   = DISP_OP;
            ent_d[i].dtag = DISP_DTAG;
            ent_d[i].qj   = byp_j ? '0 : DISP_QJ;
            ent_d[i].qk   = byp_k ? '0 : DISP_QK;
            ent_d[i].vj   = byp_j ? CDB_DATA : DISP_VJ;
            ent_d[i].vk   = byp_k ? CDB_DATA : DISP_VK;
            state_d[i]    = (ent_d[i].qj == '0 && ent_d[i].qk == '0) ? ST_READY : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (CDB_VALID && CDB_TAG != '0 && ent_q[i].qj == CDB_TAG) begin
            ent_d[i].vj = CDB_DATA;
            ent_d[i].qj = '0;
          end
          if (CDB_VALID && CDB_TAG != '0 && ent_q[i].qk == CDB_TAG) begin
            ent_d[i].vk = CDB_DATA;
            ent_d[i].qk = '0;
          end
          if (ent_d[i].qj == '0 && ent_d[i].qk == '0) state_d[i] = ST_READY;
        end
        ST_READY: begin
          if (load && sel_vec[i]) state_d[i] = ST_FREE;
        end
        default: state_d[i] = ST_FREE;
      endcase
      // The new entry becomes the youngest: clear its row, set its column in all others.
      if (disp_ok) begin
        if (tgt_vec[i]) older_d[i] = '0;
        else            older_d[i] = older_q[i] | tgt_vec;
      end
    end
    if (FLUSH) begin
      for (int i = 0; i < NUM_ENTRIES; i++) state_d[i] = ST_FREE;
    end
  end

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        state_q[i] <= ST_FREE;
        older_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        state_q[i] <= state_d[i];
        older_q[i] <= older_d[i];
      end
    end
  end

  // NOTE: the entry payload is deliberately not reset. It is only read while
  // the entry's state says it holds a valid task, so a reset would add fanout
  // for no functional gain.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < NUM_ENTRIES; i++) ent_q[i] <= ent_d[i];
  end

  // ---------------------------------------------------------------------------
  // Registered output stage: loads when empty or draining, else holds.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!RST_N || FLUSH) begin
      fu_valid_q <= 1'b0;
      fu_op_q    <= '0;
      fu_a_q     <= '0;
      fu_b_q     <= '0;
      fu_dtag_q  <= '0;
      disp_err_q <= 1'b0;
    end else begin
      disp_err_q <= disp_err_d;
      if (load) begin
        fu_valid_q <= 1'b1;
        fu_op_q    <= sel_ent.op;
        fu_a_q     <= sel_ent.vj;
        fu_b_q     <= sel_ent.vk;
        fu_dtag_q  <= sel_ent.dtag;
      end else if (FU_READY) begin
        fu_valid_q <= 1'b0;
      end
    end
  end

  assign FU_VALID = fu_valid_q;
  assign FU_OP    = fu_op_q;
  assign FU_A     = fu_a_q;
  assign FU_B     = fu_b_q;
  assign FU_DTAG  = fu_dtag_q;
  assign DISP_ERR = disp_err_q;

`ifdef RS_STATS_EN
  logic [15:0] stat_issued_q, stat_stall_q;

  // Counters observe the port handshake independently of FLUSH.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      stat_issued_q <= '0;
      stat_stall_q  <= '0;
    end else begin
      if (fu_valid_q && FU_READY && stat_issued_q != 16'hFFFF)
        stat_issued_q <= stat_issued_q + 16'd1;
      if (fu_valid_q && !FU_READY && stat_stall_q != 16'hFFFF)
        stat_stall_q <= stat_stall_q + 16'd1;
    end
  end

  assign STAT_ISSUED = stat_issued_q;
  assign STAT_STALL  = stat_stall_q;
`else
  assign STAT_ISSUED = '0;
  assign STAT_STALL  = '0;
`endif

endmodule

// File: tb/tb_alu_reservation_station.sv
// -----------------------------------------------------------------------------
// tb_alu_reservation_station
//
// Directed scenarios followed by randomized traffic. Every cycle the outputs
// are compared with a task-level reference model. The model keeps a sequence
// number per entry for age, and treats an entry as selectable once both source
// tags are clear at the start of a cycle.
// -----------------------------------------------------------------------------
module tb_alu_reservation_station;

  localparam int N    = 2;
  localparam int TAGW = 4;
  localparam int OPW  = 4;
  localparam int XLEN = 32;
  localparam int IDXW = 1;

  logic            CLK = 1'b0;
  logic            RST_N, FLUSH, DISP_VALID, CDB_VALID, FU_READY;
  logic [IDXW-1:0] DISP_IDX;
  logic [OPW-1:0]  DISP_OP;
  logic [TAGW-1:0] DISP_QJ, DISP_QK, DISP_DTAG, CDB_TAG;
  logic [XLEN-1:0] DISP_VJ, DISP_VK, CDB_DATA;
  logic [N-1:0]    BUSY;
  logic            DISP_ERR, FU_VALID;
  logic [OPW-1:0]  FU_OP;
  logic [XLEN-1:0] FU_A, FU_B;
  logic [TAGW-1:0] FU_DTAG;
  logic [15:0]     STAT_ISSUED, STAT_STALL;

  alu_reservation_station #(
    .NUM_ENTRIES(N), .TAGW(TAGW), .OPW(OPW), .XLEN(XLEN)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .FLUSH(FLUSH),
    .DISP_VALID(DISP_VALID), .DISP_IDX(DISP_IDX), .DISP_OP(DISP_OP),
    .DISP_QJ(DISP_QJ), .DISP_QK(DISP_QK), .DISP_VJ(DISP_VJ), .DISP_VK(DISP_VK),
    .DISP_DTAG(DISP_DTAG),
    .CDB_VALID(CDB_VALID), .CDB_TAG(CDB_TAG), .CDB_DATA(CDB_DATA),
    .BUSY(BUSY), .DISP_ERR(DISP_ERR),
    .FU_VALID(FU_VALID), .FU_READY(FU_READY),
    .FU_OP(FU_OP), .FU_A(FU_A), .FU_B(FU_B), .FU_DTAG(FU_DTAG),
    .STAT_ISSUED(STAT_ISSUED), .STAT_STALL(STAT_STALL)
  );

  always #5 CLK = ~CLK;

  int ncmp = 0;
  int nerr = 0;

  // Reference model state
  bit              m_busy [N];
  logic [TAGW-1:0] m_qj   [N];
  logic [TAGW-1:0] m_qk   [N];
  logic [XLEN-1:0] m_vj   [N];
  logic [XLEN-1:0] m_vk   [N];
  logic [OPW-1:0]  m_op   [N];
  logic [TAGW-1:0] m_dt   [N];
  int              m_seq  [N];
  int              next_seq = 0;
  bit              m_fv, m_err;
  logic [OPW-1:0]  m_fop;
  logic [XLEN-1:0] m_fa, m_fb;
  logic [TAGW-1:0] m_fdt;
  int              m_iss, m_stall;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear_entries();
    for (int i = 0; i < N; i++) begin
      m_busy[i] = 0;
      m_qj[i] = '0; m_qk[i] = '0;
    end
    m_fv = 0; m_fop = '0; m_fa = '0; m_fb = '0; m_fdt = '0; m_err = 0;
  endtask

  // One clock edge of the reference model, driven by the inputs held before it.
  task automatic model_step();
    int sel;
    bit load;
    if (!RST_N) begin
      model_clear_entries();
      m_iss = 0; m_stall = 0;
      return;
    end
    if (m_fv && FU_READY && m_iss < 65535) m_iss++;
    if (m_fv && !FU_READY && m_stall < 65535) m_stall++;
    if (FLUSH) begin
      model_clear_entries();
      return;
    end
    sel = -1;
    for (int i = 0; i < N; i++)
      if (m_busy[i] && m_qj[i] == 0 && m_qk[i] == 0 && (sel < 0 || m_seq[i] < m_seq[sel]))
        sel = i;
    load = (sel >= 0) && (!m_fv || FU_READY);
    for (int i = 0; i < N; i++) begin
      if (m_busy[i] && CDB_VALID && CDB_TAG != 0) begin
        if (m_qj[i] == CDB_TAG) begin m_vj[i] = CDB_DATA; m_qj[i] = '0; end
        if (m_qk[i] == CDB_TAG) begin m_vk[i] = CDB_DATA; m_qk[i] = '0; end
      end
    end
    m_err = 0;
    if (DISP_VALID) begin
      if (!m_busy[DISP_IDX]) begin
        m_busy[DISP_IDX] = 1;
        m_op[DISP_IDX]   = DISP_OP;
        m_dt[DISP_IDX]   = DISP_DTAG;
        if (CDB_VALID && CDB_TAG != 0 && DISP_QJ == CDB_TAG) begin
          m_qj[DISP_IDX] = '0; m_vj[DISP_IDX] = CDB_DATA;
        end else begin
          m_qj[DISP_IDX] = DISP_QJ; m_vj[DISP_IDX] = DISP_VJ;
        end
        if (CDB_VALID && CDB_TAG != 0 && DISP_QK == CDB_TAG) begin
          m_qk[DISP_IDX] = '0; m_vk[DISP_IDX] = CDB_DATA;
        end else begin
          m_qk[DISP_IDX] = DISP_QK; m_vk[DISP_IDX] = DISP_VK;
        end
        m_seq[DISP_IDX] = next_seq++;
      end else begin
        m_err = 1;
      end
    end
    if (load) begin
      m_fv = 1; m_fop = m_op[sel]; m_fa = m_vj[sel]; m_fb = m_vk[sel]; m_fdt = m_dt[sel];
      m_busy[sel] = 0;
    end else if (FU_READY) begin
      m_fv = 0;
    end
  endtask

  task automatic compare_all();
    logic [N-1:0] eb;
    for (int i = 0; i < N; i++) eb[i] = m_busy[i];
    check("busy", BUSY, eb);
    check("disp_err", DISP_ERR, m_err);
    check("fu_valid", FU_VALID, m_fv);
    check("fu_op", FU_OP, m_fop);
    check("fu_a", FU_A, m_fa);
    check("fu_b", FU_B, m_fb);
    check("fu_dtag", FU_DTAG, m_fdt);
`ifdef RS_STATS_EN
    check("stat_issued", STAT_ISSUED, m_iss[15:0]);
    check("stat_stall", STAT_STALL, m_stall[15:0]);
`else
    check("stat_issued", STAT_ISSUED, 16'h0);
    check("stat_stall", STAT_STALL, 16'h0);
`endif
  endtask

  task automatic tick();
    @(posedge CLK);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic idle();
    DISP_VALID = 0; CDB_VALID = 0; FLUSH = 0;
    CDB_TAG = '0; CDB_DATA = '0;
  endtask

  task automatic disp(input int idx, input int op, input int qj, input int qk,
                      input logic [XLEN-1:0] vj, input logic [XLEN-1:0] vk, input int dt);
    DISP_VALID = 1;
    DISP_IDX   = IDXW'(idx);
    DISP_OP    = OPW'(op);
    DISP_QJ    = TAGW'(qj);
    DISP_QK    = TAGW'(qk);
    DISP_VJ    = vj;
    DISP_VK    = vk;
    DISP_DTAG  = TAGW'(dt);
  endtask

  task automatic cdb(input int tag, input logic [XLEN-1:0] data);
    CDB_VALID = 1; CDB_TAG = TAGW'(tag); CDB_DATA = data;
  endtask

  initial begin
    RST_N = 0; FU_READY = 1;
    idle();
    disp(0, 1, 0, 0, 32'h1, 32'h2, 1);

    // T1: reset held two cycles with a dispatch pending
    tick();
    check("t1_busy_a", BUSY, 2'b00);
    check("t1_fuv_a", FU_VALID, 1'b0);
    tick();
    check("t1_busy_b", BUSY, 2'b00);
    check("t1_fuv_b", FU_VALID, 1'b0);
    RST_N = 1; idle();
    tick();
    check("t1_idle_busy", BUSY, 2'b00);
    check("t1_idle_fuv", FU_VALID, 1'b0);

    // T2: dispatch with both operands ready
    disp(0, 3, 0, 0, 32'd5, 32'd7, 2);
    tick();
    check("t2_busy_t1", BUSY[0], 1'b1);
    check("t2_fuv_t1", FU_VALID, 1'b0);
    idle();
    tick();
    check("t2_fuv_t2", FU_VALID, 1'b1);
    check("t2_op", FU_OP, 4'd3);
    check("t2_a", FU_A, 32'd5);
    check("t2_b", FU_B, 32'd7);
    check("t2_dtag", FU_DTAG, 4'd2);
    check("t2_busy_t2", BUSY[0], 1'b0);
    tick();
    check("t2_drop", FU_VALID, 1'b0);

    // T3: wakeup from the CDB three cycles after dispatch
    disp(1, 5, 4, 0, 32'hDEAD, 32'd9, 3);
    tick();
    idle();
    tick();
    tick();
    cdb(4, 32'h11);
    tick();
    check("t3_fuv_t1", FU_VALID, 1'b0);
    idle();
    tick();
    check("t3_fuv_t2", FU_VALID, 1'b1);
    check("t3_a", FU_A, 32'h11);
    check("t3_b", FU_B, 32'd9);
    tick();
    // T3b: bypass in the dispatch cycle
    disp(1, 6, 4, 0, 32'hBEEF, 32'd9, 3);
    cdb(4, 32'h22);
    tick();
    check("t3b_fuv_t1", FU_VALID, 1'b0);
    idle();
    tick();
    check("t3b_fuv_t2", FU_VALID, 1'b1);
    check("t3b_a", FU_A, 32'h22);
    tick();

    // T5: collision with an occupied entry
    disp(0, 9, 5, 0, 32'h0, 32'h1, 6);
    tick();
    disp(0, 10, 0, 0, 32'hAA, 32'hBB, 7);
    tick();
    check("t5_err", DISP_ERR, 1'b1);
    check("t5_busy", BUSY[0], 1'b1);
    idle();
    tick();
    check("t5_err_clr", DISP_ERR, 1'b0);
    cdb(5, 32'h33);
    tick();
    idle();
    tick();
    check("t5_fuv", FU_VALID, 1'b1);
    check("t5_op", FU_OP, 4'd9);
    check("t5_a", FU_A, 32'h33);
    check("t5_dtag", FU_DTAG, 4'd6);
    tick();

    // T4: age order under backpressure (fresh counters)
    RST_N = 0;
    tick();
    RST_N = 1; FU_READY = 0;
    disp(1, 11, 0, 0, 32'h100, 32'h101, 8);
    tick();
    disp(0, 12, 0, 0, 32'h200, 32'h201, 9);
    tick();
    idle();
    for (int k = 0; k < 5; k++) begin
      check("t4_hold_v", FU_VALID, 1'b1);
      check("t4_hold_op", FU_OP, 4'd11);
      check("t4_hold_busy0", BUSY[0], 1'b1);
      tick();
    end
    FU_READY = 1;
    tick();
    check("t4_second_v", FU_VALID, 1'b1);
    check("t4_second_op", FU_OP, 4'd12);
    tick();
    check("t4_drained", FU_VALID, 1'b0);
`ifdef RS_STATS_EN
    check("t4_stall", STAT_STALL, 16'd5);
    check("t4_issued", STAT_ISSUED, 16'd2);
`endif

    // T6: flush with waiting entries and a loaded output stage
    FU_READY = 0;
    disp(0, 1, 0, 0, 32'h1, 32'h2, 1);
    tick();
    idle();
    tick();
    disp(0, 2, 6, 0, 32'h0, 32'h3, 2);
    tick();
    disp(1, 4, 0, 7, 32'h4, 32'h0, 3);
    tick();
    check("t6_busy_pre", BUSY, 2'b11);
    check("t6_fuv_pre", FU_VALID, 1'b1);
    disp(0, 5, 0, 0, 32'h5, 32'h6, 4);
    FLUSH = 1;
    tick();
    check("t6_busy", BUSY, 2'b00);
    check("t6_fuv", FU_VALID, 1'b0);
    check("t6_op", FU_OP, 4'd0);
    idle();
    tick();
    check("t6_dropped", BUSY, 2'b00);
    FU_READY = 1;

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      RST_N      = ($urandom_range(0, 499) != 0);
      FLUSH      = ($urandom_range(0, 79) == 0);
      FU_READY   = ($urandom_range(0, 9) < 7);
      DISP_VALID = $urandom_range(0, 1);
      DISP_IDX   = IDXW'($urandom_range(0, N - 1));
      DISP_OP    = OPW'($urandom);
      DISP_QJ    = ($urandom_range(0, 2) == 0) ? TAGW'($urandom_range(1, 5)) : '0;
      DISP_QK    = ($urandom_range(0, 2) == 0) ? TAGW'($urandom_range(1, 5)) : '0;
      DISP_VJ    = $urandom;
      DISP_VK    = $urandom;
      DISP_DTAG  = TAGW'($urandom);
      CDB_VALID  = $urandom_range(0, 1);
      CDB_TAG    = TAGW'($urandom_range(0, 5));
      CDB_DATA   = $urandom;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
